// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting, parity/framing/break detection
// and a show-ahead FIFO holding each received word together with its error flags.
module uart_rx_fifo #(
    parameter int DIV_RATE   = 260,
    parameter int DATA_W     = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_frame_err,
    output logic                          rd_parity_err,
    output logic                          rd_break,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          rx_busy,
    output logic                          rx_end,
    output logic                          overrun
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(DIV_RATE);
    localparam int EW = DATA_W + 3;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t            state;
    logic              rx_m, rx_s;
    logic [1:0]        hist;
    logic [DW-1:0]     div_cnt;
    logic [3:0]        bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              par_acc, zero_acc, perr, ferr, brk;

    logic              sample, voted, commit, last_stop, brk_now, ferr_now;
    logic              wr, rd;
    logic [EW-1:0]     wdata;
    logic [EW-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;

    assign sample    = (div_cnt == '0);
    assign voted     = (rx_s & hist[0]) | (rx_s & hist[1]) | (hist[0] & hist[1]);
    assign last_stop = (bit_cnt == 4'(STOP_BITS - 1));
    assign commit    = (state == STOP) && sample && last_stop;

    // The committed word must include the stop bit being sampled right now.
    assign ferr_now  = ferr | ~voted;
    assign brk_now   = (bit_cnt == 4'd0) ? (zero_acc & ~voted) : brk;
    assign wdata     = {brk_now, perr, ferr_now, shreg};

    assign rx_busy   = (state != IDLE);
    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign wr        = !reset && commit && (!full || rd_en);
    assign rd        = !reset && rd_en && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rx_m     <= 1'b1;
            rx_s     <= 1'b1;
            hist     <= 2'b11;
            div_cnt  <= DW'(1);
            bit_cnt  <= 4'd1;
            shreg    <= '0;
            par_acc  <= 1'b0;
            zero_acc <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            brk      <= 1'b0;
            rx_end   <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            rx_m    <= rx;
            rx_s    <= rx_m;
            hist    <= {hist[0], rx_s};
            rx_end  <= commit;
            overrun <= commit && full && !rd_en;
            if (state == IDLE) begin
                if (!rx_s) begin
                    state   <= START;
                    div_cnt <= DW'(DIV_RATE/2 - 1);
                end
            end else if (!sample) begin
                div_cnt <= div_cnt - DW'(1);
            end else begin
                div_cnt <= DW'(DIV_RATE - 1);
                case (state)
                    START: begin
                        if (voted) begin
                            state <= IDLE;
                        end else begin
                            state    <= DATA;
                            bit_cnt  <= 4'd0;
                            par_acc  <= 1'b0;
                            zero_acc <= 1'b1;
                            perr     <= 1'b0;
                            ferr     <= 1'b0;
                            brk      <= 1'b0;
                        end
                    end
                    DATA: begin
                        shreg    <= {voted, shreg[DATA_W-1:1]};
                        par_acc  <= par_acc ^ voted;
                        zero_acc <= zero_acc & ~voted;
                        if (bit_cnt == 4'(DATA_W - 1)) begin
                            bit_cnt <= 4'd0;
                            state   <= (PARITY != 0) ? PAR : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    PAR: begin
                        perr     <= (PARITY == 1) ? ~(par_acc ^ voted) : (par_acc ^ voted);
                        zero_acc <= zero_acc & ~voted;
                        state    <= STOP;
                    end
                    STOP: begin
                        ferr <= ferr_now;
                        brk  <= brk_now;
                        if (last_stop) begin
                            state <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + AW'(1);
            if (rd) rd_ptr <= rd_ptr + AW'(1);
            if (wr && !rd)      count <= count + (AW+1)'(1);
            else if (rd && !wr) count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= wdata;
    end

    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign {rd_break, rd_parity_err, rd_frame_err, rd_data} = empty ? '0 : mem[rd_ptr];
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frames are driven bit by bit, expected
// FIFO words are queued at send time and checked as the FIFO is drained.
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       reset, rx, rd_en;
    logic [7:0] rd_data;
    logic       rd_frame_err, rd_parity_err, rd_break;
    logic       empty, full, rx_busy, rx_end, overrun;
    logic [2:0] count;

    int n_cmp = 0;
    int n_err = 0;
    int end_cnt = 0;
    int ovr_cnt = 0;
    int e0, o0;
    logic [10:0] exp_q[$];
    logic [7:0]  d;

    uart_rx_fifo #(
        .DIV_RATE(16), .DATA_W(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .rx(rx), .rd_en(rd_en),
        .rd_data(rd_data), .rd_frame_err(rd_frame_err),
        .rd_parity_err(rd_parity_err), .rd_break(rd_break),
        .empty(empty), .full(full), .count(count),
        .rx_busy(rx_busy), .rx_end(rx_end), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_end)  end_cnt++;
        if (overrun) ovr_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected word {break, parity_err, frame_err, data} under even parity.
    function automatic logic [10:0] exp_word(input logic [7:0] dv, input logic p, input logic s);
        logic b;
        b = (dv == 8'h00) && !p && !s;
        return {b, (^dv) ^ p, ~s, dv};
    endfunction

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) step();
    endtask

    // 11 bit cells of 16 clocks: start, 8 data LSB first, parity, stop.
    task automatic send_frame(input logic [7:0] dv, input logic p, input logic s,
                              input bit rd_at_commit, input bit glitch);
        logic [10:0] bits;
        bits = {s, p, dv, 1'b0};
        for (int c = 0; c < 176; c++) begin
            rx = bits[c/16];
            if (glitch && (c % 16) == 8) rx = ~bits[c/16];
            if (rd_at_commit) begin
                if (c == 170) begin
                    check("head_at_commit",
                          {21'd0, rd_break, rd_parity_err, rd_frame_err, rd_data},
                          {21'd0, exp_q[0]});
                    void'(exp_q.pop_front());
                    rd_en = 1'b1;
                end else begin
                    rd_en = 1'b0;
                end
            end
            step();
        end
        rx    = 1'b1;
        rd_en = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        logic [10:0] e;
        check({tag, "_not_empty"}, {31'd0, empty}, 32'd0);
        e = exp_q.pop_front();
        check(tag, {21'd0, rd_break, rd_parity_err, rd_frame_err, rd_data}, {21'd0, e});
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) pop_check(tag);
        check({tag, "_empty_after"}, {31'd0, empty}, 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        rd_en = 1'b0;
        repeat (3) step();
        check("rst_empty",   {31'd0, empty},   32'd1);
        check("rst_full",    {31'd0, full},    32'd0);
        check("rst_count",   {29'd0, count},   32'd0);
        check("rst_busy",    {31'd0, rx_busy}, 32'd0);
        check("rst_end",     {31'd0, rx_end},  32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_rd",      {21'd0, rd_break, rd_parity_err, rd_frame_err, rd_data}, 32'd0);
        reset = 1'b0;
        idle(4);

        // Clean frame
        e0 = end_cnt;
        exp_q.push_back(exp_word(8'hA5, 1'b0, 1'b1));
        send_frame(8'hA5, 1'b0, 1'b1, 0, 0);
        check("a5_end_pulses", end_cnt, e0 + 1);
        check("a5_count", {29'd0, count}, 32'd1);
        drain("a5");

        // Short low pulse is rejected as a start glitch
        e0 = end_cnt;
        rx = 1'b0;
        repeat (5) step();
        idle(20);
        check("glitch_busy",  {31'd0, rx_busy}, 32'd0);
        check("glitch_end",   end_cnt, e0);
        check("glitch_count", {29'd0, count}, 32'd0);

        // Parity error, then framing error
        exp_q.push_back(exp_word(8'h3C, 1'b1, 1'b1));
        send_frame(8'h3C, 1'b1, 1'b1, 0, 0);
        exp_q.push_back(exp_word(8'h3C, 1'b0, 1'b0));
        send_frame(8'h3C, 1'b0, 1'b0, 0, 0);
        idle(20);
        check("err_count", {29'd0, count}, 32'd2);
        drain("err");

        // Break: 00 data with a 0 parity bit is valid even parity, so only
        // break and frame_err are set. The line is still low when the FSM
        // returns to IDLE, so a second frame starts and reads all ones once
        // the line is released: data FF with a parity bit of 1 is a parity error.
        e0 = end_cnt;
        exp_q.push_back(exp_word(8'h00, 1'b0, 1'b0));
        exp_q.push_back(11'b010_1111_1111);
        rx = 1'b0;
        repeat (192) step();
        idle(180);
        check("brk_end", end_cnt, e0 + 2);
        check("brk_count", {29'd0, count}, 32'd2);
        drain("brk");

        // Overrun when the fifth frame meets a full FIFO
        e0 = end_cnt;
        o0 = ovr_cnt;
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom_range(0, 255));
            if (i < 4) exp_q.push_back(exp_word(d, ^d, 1'b1));
            send_frame(d, ^d, 1'b1, 0, 0);
        end
        check("ovr_pulse", ovr_cnt, o0 + 1);
        check("ovr_end",   end_cnt, e0 + 5);
        check("ovr_count", {29'd0, count}, 32'd4);
        check("ovr_full",  {31'd0, full},  32'd1);
        drain("ovr");

        // Read in the commit cycle lets the write into a full FIFO succeed
        o0 = ovr_cnt;
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom_range(0, 255));
            exp_q.push_back(exp_word(d, ^d, 1'b1));
            send_frame(d, ^d, 1'b1, i == 4, 0);
        end
        check("rdw_no_ovr", ovr_cnt, o0);
        check("rdw_count", {29'd0, count}, 32'd4);
        drain("rdw");

        // One-clock glitches at every sample point are outvoted
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom_range(0, 255));
            exp_q.push_back(exp_word(d, ^d, 1'b1));
            send_frame(d, ^d, 1'b1, 0, 1);
        end
        drain("vote");

        // Reset in the middle of a frame
        exp_q.push_back(exp_word(8'h81, 1'b0, 1'b1));
        send_frame(8'h81, 1'b0, 1'b1, 0, 0);
        rx = 1'b0;
        repeat (16) step();
        rx = 1'b1;
        repeat (16) step();
        rx = 1'b0;
        repeat (10) step();
        check("mid_busy_before", {31'd0, rx_busy}, 32'd1);
        reset = 1'b1;
        rx    = 1'b1;
        step();
        exp_q.delete();
        check("mid_busy",  {31'd0, rx_busy}, 32'd0);
        check("mid_empty", {31'd0, empty},   32'd1);
        check("mid_count", {29'd0, count},   32'd0);
        check("mid_rd",    {21'd0, rd_break, rd_parity_err, rd_frame_err, rd_data}, 32'd0);
        reset = 1'b0;
        idle(5);
        exp_q.push_back(exp_word(8'h55, 1'b0, 1'b1));
        send_frame(8'h55, 1'b0, 1'b1, 0, 0);
        drain("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
